sync_req_ctrl: RTL and testbench

- Initiator-side controller for the pulse-synchronizer request/ready protocol.
- Turns user request strobes into single-cycle start pulses with guaranteed spacing, then waits for the ready/ack pulse returned through the destination-domain synchronizer.
- Resolves each request as done, retried or failed on timeout.
- Lives entirely in the source clock domain. The ack input is already synchronized into this domain.

---
 rtl/sync_pkg.sv | 11 +
 rtl/sync_cnt.sv | 23 ++
 rtl/sync_req_ctrl.sv | 117 +++++++++++
 tb/tb_sync_req_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared state encoding, default parameters and counter width helper for sync_req_ctrl
package sync_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GUARD} state_e;
  localparam int SYNC_TIMEOUT_DEF = 64;
  localparam int SYNC_RETRIES_DEF = 2;
  localparam int SYNC_GUARD_DEF   = 4;
  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_cnt.sv
// sync_cnt: loadable down-counter that stops at zero and flags it
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load val_i (takes priority over dec_i)
//   dec_i    : decrement while nonzero
//   val_i    : load value
//   zero_o   : count is zero
module sync_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sync_req_ctrl.sv
// sync_req_ctrl: initiator-side request/ready controller for a pulse synchronizer
//   clk, rst : clock, synchronous active-high reset
//   req      : request strobe, queued in pend_cnt until issued
//   ack      : ready pulse, already synchronized into this domain
//   start    : one-cycle start pulse to the synchronizer
//   busy     : controller not idle
//   done/err : request acknowledged / final retry timed out
//   overflow : request dropped because the queue was full
//   pend_cnt : queued requests not yet issued
module sync_req_ctrl
  import sync_pkg::*;
#(
  parameter int TIMEOUT = SYNC_TIMEOUT_DEF,
  parameter int RETRIES = SYNC_RETRIES_DEF,
  parameter int GUARD   = SYNC_GUARD_DEF,
  parameter int PEND_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              ack,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic [PEND_W-1:0] pend_cnt
);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int GW = cnt_w(GUARD);
  localparam int RW = cnt_w(RETRIES + 1);
  state_e state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic retry_q, retry_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic consume, inc, full, t_load, g_load, t_zero, g_zero, have_req;
  // Timer and guard counters hold "cycles remaining minus one", so zero marks the last cycle.
  sync_cnt #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load_i(t_load), .dec_i(state_q == S_WAIT),
    .val_i(TW'(TIMEOUT - 1)), .zero_o(t_zero)
  );
  sync_cnt #(.W(GW)) u_guard (
    .clk(clk), .rst(rst), .load_i(g_load), .dec_i(state_q == S_GUARD),
    .val_i(GW'(GUARD - 1)), .zero_o(g_zero)
  );
  assign have_req = pend_q != '0 || req;
  assign full     = pend_q == '1;
  assign inc      = req && !(full && !consume);
  assign pend_d   = pend_q + PEND_W'(inc) - PEND_W'(consume);
  assign ovf_d    = req && full && !consume;
  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    t_load  = 1'b0;
    g_load  = 1'b0;
    retry_d = retry_q;
    rcnt_d  = rcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (have_req) begin
        state_d = S_PULSE;
        consume = 1'b1;
      end
      S_PULSE: begin
        state_d = S_WAIT;
        t_load  = 1'b1;
      end
      S_WAIT: if (ack || t_zero) begin
        // ack beats a same-cycle timeout
        state_d = S_GUARD;
        g_load  = 1'b1;
        if (ack) begin
          done_d = 1'b1;
          rcnt_d = '0;
        end else if (rcnt_q < RW'(RETRIES)) begin
          rcnt_d  = rcnt_q + RW'(1);
          retry_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          rcnt_d = '0;
        end
      end
      S_GUARD: if (g_zero) begin
        // a pending retry reissues the same request, so nothing is consumed
        state_d = (retry_q || have_req) ? S_PULSE : S_IDLE;
        consume = !retry_q && have_req;
        retry_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rcnt_q  <= '0;
      retry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rcnt_q  <= rcnt_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  assign start    = state_q == S_PULSE;
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign err      = err_q;
  assign overflow = ovf_q;
  assign pend_cnt = pend_q;
endmodule

// File: tb/tb_sync_req_ctrl.sv
// tb_sync_req_ctrl: directed cycle-trace checks of sync_req_ctrl (TIMEOUT=8, RETRIES=1, GUARD=2, PEND_W=2)
module tb_sync_req_ctrl;
  logic clk, rst, req, ack, start, busy, done, err, overflow;
  logic [1:0] pend_cnt;
  logic [63:0] tr_st, tr_busy, tr_done, tr_err, tr_ovf;
  logic [63:0] tr_pend [64];
  logic [63:0] pk;
  int n_tests, n_fail;
  sync_req_ctrl #(.TIMEOUT(8), .RETRIES(1), .GUARD(2), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .start(start), .busy(busy),
    .done(done), .err(err), .overflow(overflow), .pend_cnt(pend_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  // Cycle c runs from one rising edge to the next: outputs are sampled 1 time unit
  // into the cycle, then that cycle's inputs are applied.
  task automatic run(input logic [63:0] rq, input logic [63:0] ak, input int n, input int rst_at);
    tr_st = '0; tr_busy = '0; tr_done = '0; tr_err = '0; tr_ovf = '0;
    for (int c = 0; c < 64; c++) tr_pend[c] = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      tr_st[c] = start;
      tr_busy[c] = busy;
      tr_done[c] = done;
      tr_err[c] = err;
      tr_ovf[c] = overflow;
      tr_pend[c] = 64'(pend_cnt);
      req = rq[c];
      ack = ak[c];
      rst = (c == rst_at);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    ack = 1'b0;
    rst = 1'b0;
  endtask
  initial begin
    clk = 1'b0;
    n_tests = 0;
    n_fail = 0;
    do_reset();
    run(64'h1, 64'h10, 12, -1);
    chk("reset_outs", 64'({tr_st[0], tr_busy[0], tr_done[0], tr_err[0], tr_ovf[0]}), 64'h0);
    chk("reset_pend", tr_pend[0], 64'h0);
    chk("basic_start", tr_st, 64'h2);
    chk("basic_done", tr_done, 64'h20);
    chk("basic_busy", tr_busy, 64'h7E);
    chk("basic_err", tr_err, 64'h0);
    for (int k = 0; k < 2; k++) begin
      run(64'h1, 64'h0, 26, -1);
      chk("retry_err_start", tr_st, 64'h1002);
      chk("retry_err_err", tr_err, 64'h200000);
      chk("retry_err_busy", tr_busy, 64'h7FFFFE);
      chk("retry_err_done", tr_done, 64'h0);
    end
    run(64'h1, 64'h4000, 22, -1);
    chk("retry_ok_start", tr_st, 64'h1002);
    chk("retry_ok_done", tr_done, 64'h8000);
    chk("retry_ok_err", tr_err, 64'h0);
    chk("retry_ok_busy", tr_busy, 64'h1FFFE);
    run(64'h1F, 64'h42108, 26, -1);
    pk = '0;
    for (int c = 0; c < 26; c++) if (tr_pend[c] > pk) pk = tr_pend[c];
    chk("queue_peak", pk, 64'd3);
    chk("queue_pend4", tr_pend[4], 64'd3);
    chk("queue_pend6", tr_pend[6], 64'd2);
    chk("queue_pend11", tr_pend[11], 64'd1);
    chk("queue_pend16", tr_pend[16], 64'd0);
    chk("queue_ovf", tr_ovf, 64'h20);
    chk("queue_start", tr_st, 64'h10842);
    chk("queue_done", tr_done, 64'h84210);
    chk("queue_busy", tr_busy, 64'h1FFFFE);
    chk("queue_err", tr_err, 64'h0);
    run(64'h1, 64'h200, 16, -1);
    chk("expiry_start", tr_st, 64'h2);
    chk("expiry_done", tr_done, 64'h400);
    chk("expiry_err", tr_err, 64'h0);
    chk("expiry_busy", tr_busy, 64'hFFE);
    run(64'h4, 64'h5CB, 14, -1);
    chk("stray_start", tr_st, 64'h8);
    chk("stray_done", tr_done, 64'h80);
    chk("stray_busy", tr_busy, 64'h1F8);
    chk("stray_err", tr_err, 64'h0);
    run(64'h103, 64'h0, 14, 6);
    chk("rst_pend6", tr_pend[6], 64'd1);
    chk("rst_outs7", 64'({tr_st[7], tr_busy[7], tr_done[7], tr_err[7], tr_ovf[7]}), 64'h0);
    chk("rst_pend7", tr_pend[7], 64'd0);
    chk("rst_start", tr_st, 64'h202);
    chk("rst_busy", tr_busy, 64'h3E7E);
    chk("rst_done", tr_done, 64'h0);
    chk("rst_err", tr_err, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
